// File: rtl/store_buffer_if.sv
// CPU-side and dmem-side signal bundle of the posted-write store buffer.
// The slave modport is the buffer's view; master is the CPU/dmem side.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]        cpu_address;
    logic [DATA_W-1:0]        cpu_writeData;
    logic                     cpu_MemWrite;
    logic                     cpu_MemRead;
    logic [DATA_W-1:0]        cpu_ReadData;
    logic                     stall;
    logic                     mem_ready;
    logic [ADDR_W-1:0]        mem_address;
    logic [DATA_W-1:0]        mem_writeData;
    logic                     mem_MemWrite;
    logic                     mem_MemRead;
    logic [DATA_W-1:0]        mem_ReadData;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;

    modport slave (
        input  cpu_address, cpu_writeData, cpu_MemWrite, cpu_MemRead,
        input  mem_ready, mem_ReadData,
        output cpu_ReadData, stall, mem_address, mem_writeData,
        output mem_MemWrite, mem_MemRead, count, empty, full
    );

    modport master (
        output cpu_address, cpu_writeData, cpu_MemWrite, cpu_MemRead,
        output mem_ready, mem_ReadData,
        input  cpu_ReadData, stall, mem_address, mem_writeData,
        input  mem_MemWrite, mem_MemRead, count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of CPU stores drained to dmem when
// the port is free, with load forwarding from the youngest matching entry.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    store_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;

    logic              is_full;
    logic              load_req;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              load_miss;
    logic              drain;
    logic              enq;

    assign is_full   = (count_q == CNT_W'(DEPTH));
    // A store wins over a simultaneous (illegal) load; the load is dropped.
    assign load_req  = bus.cpu_MemRead & ~bus.cpu_MemWrite;
    assign enq       = bus.cpu_MemWrite & ~is_full;
    assign load_miss = load_req & ~hit;
    assign drain     = (count_q != '0) & bus.mem_ready & ~load_miss;

    // Walk oldest to youngest so the last match seen is the youngest store.
    // Pointer sums are PTR_W wide, so DEPTH being a power of two makes wrap free.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (addr_mem[head + PTR_W'(i)][ADDR_W-1:2] == bus.cpu_address[ADDR_W-1:2])) begin
                hit      = 1'b1;
                hit_data = data_mem[head + PTR_W'(i)];
            end
        end
    end

    always_comb begin
        bus.cpu_ReadData  = '0;
        bus.mem_MemRead   = 1'b0;
        bus.mem_MemWrite  = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writeData = '0;
        if (load_miss) begin
            bus.mem_MemRead  = 1'b1;
            bus.mem_address  = bus.cpu_address;
            bus.cpu_ReadData = bus.mem_ReadData;
        end else begin
            if (load_req) bus.cpu_ReadData = hit_data;
            if (drain) begin
                bus.mem_MemWrite  = 1'b1;
                bus.mem_address   = addr_mem[head];
                bus.mem_writeData = data_mem[head];
            end
        end
    end

    assign bus.stall = bus.cpu_MemWrite & is_full;
    assign bus.count = count_q;
    assign bus.empty = (count_q == '0);
    assign bus.full  = is_full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq)   tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            case ({enq, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: entry storage is deliberately not reset; validity is carried
    // entirely by head/tail/count, and unreset arrays map onto plain RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= bus.cpu_address;
            data_mem[tail] <= bus.cpu_writeData;
        end
    end

    a_no_load_with_store: assert property (
        @(posedge clk) disable iff (rst) !(bus.cpu_MemWrite && bus.cpu_MemRead)
    ) else $error("store_buffer: cpu_MemWrite and cpu_MemRead asserted together");

endmodule

// File: tb/tb_store_buffer.sv
// Vector-table bench for store_buffer with a dmem model and an in-order
// scoreboard of accepted stores that is checked against every drain.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic        we, re, rdy;
        logic [31:0] addr, wdata;
        logic [31:0] e_rdata;
        logic        e_mwe, e_mre;
        logic [31:0] e_maddr, e_mwdata;
        logic        e_stall;
        int          e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] dmem [64];
    int          n_checks;
    int          n_fail;
    entry_t      sb_q[$];
    vec_t        vecs[$];

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.mem_ReadData = dmem[bus.mem_address[7:2]];

    always @(posedge clk) begin
        if (bus.mem_MemWrite) dmem[bus.mem_address[7:2]] <= bus.mem_writeData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, re, rdy, input logic [31:0] addr, wdata,
                                input logic [31:0] e_rdata, input logic e_mwe, e_mre,
                                input logic [31:0] e_maddr, e_mwdata,
                                input logic e_stall, input int e_cnt);
        vec_t v;
        v.we = we; v.re = re; v.rdy = rdy; v.addr = addr; v.wdata = wdata;
        v.e_rdata = e_rdata; v.e_mwe = e_mwe; v.e_mre = e_mre;
        v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        v.e_stall = e_stall; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic we, re, rdy, input logic [31:0] addr, wdata);
        bus.cpu_MemWrite  = we;
        bus.cpu_MemRead   = re;
        bus.mem_ready     = rdy;
        bus.cpu_address   = addr;
        bus.cpu_writeData = wdata;
    endtask

    // Drive one cycle, check combinational outputs mid-cycle, then state after the edge.
    task automatic apply(input vec_t v, input int k);
        entry_t e;
        drive(v.we, v.re, v.rdy, v.addr, v.wdata);
        @(negedge clk);
        check($sformatf("v%0d cpu_ReadData", k),  bus.cpu_ReadData,        v.e_rdata);
        check($sformatf("v%0d mem_MemWrite", k),  32'(bus.mem_MemWrite),   32'(v.e_mwe));
        check($sformatf("v%0d mem_MemRead", k),   32'(bus.mem_MemRead),    32'(v.e_mre));
        check($sformatf("v%0d mem_address", k),   bus.mem_address,         v.e_maddr);
        check($sformatf("v%0d mem_writeData", k), bus.mem_writeData,       v.e_mwdata);
        check($sformatf("v%0d stall", k),         32'(bus.stall),          32'(v.e_stall));
        if (bus.mem_MemWrite) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL v%0d drain: got a dmem write, expected no pending store", k);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d sb addr", k), bus.mem_address,   e.addr);
                check($sformatf("v%0d sb data", k), bus.mem_writeData, e.data);
            end
        end
        if (v.we && !v.e_stall) sb_q.push_back('{addr: v.addr, data: v.wdata});
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", k), 32'(bus.count), 32'(v.e_cnt));
        check($sformatf("v%0d empty", k), 32'(bus.empty), 32'(v.e_cnt == 0));
        check($sformatf("v%0d full", k),  32'(bus.full),  32'(v.e_cnt == DEPTH));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'hD000_0000 | 32'(i);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Single store, drain, load-back from dmem
        vecs.push_back(mk(1,0,1, 32'h4,  32'hA5A5A5A5, 32'h0,        0,0, 32'h0,  32'h0,        0, 1));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h4,  32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk(0,1,1, 32'h4,  32'h0,        32'hA5A5A5A5, 0,1, 32'h4,  32'h0,        0, 0));
        // Forwarding while dmem is busy
        vecs.push_back(mk(1,0,0, 32'h8,  32'hDEADBEEF, 32'h0,        0,0, 32'h0,  32'h0,        0, 1));
        vecs.push_back(mk(0,1,0, 32'h8,  32'h0,        32'hDEADBEEF, 0,0, 32'h0,  32'h0,        0, 1));
        // Youngest-match forwarding, then in-order drain of same-address stores
        vecs.push_back(mk(1,0,0, 32'h10, 32'h11111111, 32'h0,        0,0, 32'h0,  32'h0,        0, 2));
        vecs.push_back(mk(1,0,0, 32'h10, 32'h22222222, 32'h0,        0,0, 32'h0,  32'h0,        0, 3));
        vecs.push_back(mk(0,1,0, 32'h10, 32'h0,        32'h22222222, 0,0, 32'h0,  32'h0,        0, 3));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h8,  32'hDEADBEEF, 0, 2));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h10, 32'h11111111, 0, 1));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h10, 32'h22222222, 0, 0));
        // Fill, stall, drain with wrap; blocked store lands after the first drain
        vecs.push_back(mk(1,0,0, 32'h0,  32'hA0,       32'h0,        0,0, 32'h0,  32'h0,        0, 1));
        vecs.push_back(mk(1,0,0, 32'h4,  32'hA1,       32'h0,        0,0, 32'h0,  32'h0,        0, 2));
        vecs.push_back(mk(1,0,0, 32'h8,  32'hA2,       32'h0,        0,0, 32'h0,  32'h0,        0, 3));
        vecs.push_back(mk(1,0,0, 32'hC,  32'hA3,       32'h0,        0,0, 32'h0,  32'h0,        0, 4));
        vecs.push_back(mk(1,0,0, 32'h14, 32'hA4,       32'h0,        0,0, 32'h0,  32'h0,        1, 4));
        vecs.push_back(mk(1,0,1, 32'h14, 32'hA4,       32'h0,        1,0, 32'h0,  32'hA0,       1, 3));
        vecs.push_back(mk(1,0,1, 32'h14, 32'hA4,       32'h0,        1,0, 32'h4,  32'hA1,       0, 3));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h8,  32'hA2,       0, 2));
        // Load miss owns the port; drain resumes next cycle
        vecs.push_back(mk(0,1,1, 32'h20, 32'h0,        32'hD0000008, 0,1, 32'h20, 32'h0,        0, 2));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'hC,  32'hA3,       0, 1));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h14, 32'hA4,       0, 0));
        vecs.push_back(mk(0,1,1, 32'h14, 32'h0,        32'hA4,       0,1, 32'h14, 32'h0,        0, 0));
        // Load hit with a concurrent drain
        vecs.push_back(mk(1,0,0, 32'h18, 32'hB0,       32'h0,        0,0, 32'h0,  32'h0,        0, 1));
        vecs.push_back(mk(1,0,0, 32'h1C, 32'hB1,       32'h0,        0,0, 32'h0,  32'h0,        0, 2));
        vecs.push_back(mk(0,1,1, 32'h1C, 32'h0,        32'hB1,       1,0, 32'h18, 32'hB0,       0, 1));
        vecs.push_back(mk(0,0,1, 32'h0,  32'h0,        32'h0,        1,0, 32'h1C, 32'hB1,       0, 0));
        // Three stores left pending for the mid-cycle reset sequence
        vecs.push_back(mk(1,0,0, 32'h30, 32'hC0,       32'h0,        0,0, 32'h0,  32'h0,        0, 1));
        vecs.push_back(mk(1,0,0, 32'h34, 32'hC1,       32'h0,        0,0, 32'h0,  32'h0,        0, 2));
        vecs.push_back(mk(1,0,0, 32'h38, 32'hC2,       32'h0,        0,0, 32'h0,  32'h0,        0, 3));

        #2;
        check("reset count",         32'(bus.count),        32'h0);
        check("reset empty",         32'(bus.empty),        32'h1);
        check("reset full",          32'(bus.full),         32'h0);
        check("reset stall",         32'(bus.stall),        32'h0);
        check("reset mem_MemWrite",  32'(bus.mem_MemWrite), 32'h0);
        check("reset mem_MemRead",   32'(bus.mem_MemRead),  32'h0);
        check("reset mem_address",   bus.mem_address,       32'h0);
        check("reset mem_writeData", bus.mem_writeData,     32'h0);
        check("reset cpu_ReadData",  bus.cpu_ReadData,      32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

        // Asynchronous reset between edges with a drain in flight
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        check("pre-reset mem_MemWrite", 32'(bus.mem_MemWrite), 32'h1);
        rst = 1'b1;
        #1;
        check("async reset count",        32'(bus.count),        32'h0);
        check("async reset empty",        32'(bus.empty),        32'h1);
        check("async reset mem_MemWrite", 32'(bus.mem_MemWrite), 32'h0);
        check("async reset mem_address",  bus.mem_address,       32'h0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(0,1,1, 32'h30, 32'h0, 32'hD000000C, 0,1, 32'h30, 32'h0, 0, 0), 99);

        check("scoreboard drained", 32'(sb_q.size()), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
